iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring divider in the EXE stage. Executes DIV and DIVU for the HI/LO path.
- Drives o_busy to the pipeline controller's divider-busy input, which stalls all stages while the divider runs.
- Holds its quotient and remainder results until the next accepted start.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be 2 or more.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  reset, synchronous, active-low.
- i_start  in  1  start request; sampled only in IDLE.
- i_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with i_start.
- i_dividend  in  WIDTH  dividend; sampled with i_start.
- i_divisor  in  WIDTH  divisor; sampled with i_start.
- i_cancel  in  1  synchronous abort (exception flush from MEM).
- o_busy  out  1  high while an operation is in flight, including the start cycle.
- o_done  out  1  one-cycle pulse when results are updated.
- o_quotient  out  WIDTH  quotient (goes to LO); held.
- o_remainder  out  WIDTH  remainder (goes to HI); held.
- o_div_by_zero  out  1  flag for the last completed operation, divisor was zero; held.

Behaviour:
- Reset: state=IDLE. All of o_busy, o_done, o_quotient, o_remainder and o_div_by_zero are 0. Reset overrides any in-flight operation and i_cancel.
- FSM states: IDLE, CALC, FIX, DONE.
- o_busy = (state==CALC) | (state==FIX) | (state==IDLE & i_start & ~i_cancel).
  - o_busy rises combinationally in the start cycle, so the controller's registered busy flag captures it at that same edge.
- IDLE transitions:
  - If i_start & ~i_cancel: latch operands and signs. Store |dividend| and |divisor|, taking the absolute value only if i_signed. Set count=WIDTH.
  - Divisor==0: go to DONE.
  - Otherwise: go to CALC.
- CALC, one bit per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor_abs, computed at WIDTH+1 bits.
  - If trial is non-negative: rem=trial and quo[0]=1.
  - Decrement count. After WIDTH iterations go to FIX.
- FIX:
  - Negate quo if i_signed and the operand signs differ.
  - Negate rem if i_signed and the dividend is negative.
  - Remainder sign follows the dividend.
  - Go to DONE.
- DONE:
  - Write o_quotient, o_remainder and o_div_by_zero.
  - o_done=1 for this cycle only; o_busy=0.
  - Go to IDLE.
- Latency, normal path: start at cycle 0; CALC on cycles 1..WIDTH; FIX on cycle WIDTH+1; DONE on cycle WIDTH+2, i.e. cycle 34 for WIDTH=32.
- Divide by zero: DONE at cycle 1. Result is o_quotient = all ones, o_remainder = original dividend, o_div_by_zero=1.
- Overflow, signed MIN / -1: o_quotient=MIN (0x80000000), o_remainder=0. No flag is raised.
- i_start while not in IDLE (including DONE): ignored. The operands are not re-latched.
- i_cancel in CALC or FIX: next state is IDLE. There is no o_done, and the outputs keep their previous values.
- i_cancel in DONE: ignored. The result commits.
- i_cancel together with i_start in IDLE: no start, and o_busy stays 0.
- Outputs are constant when state is not DONE.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the divisor is non-zero and |dividend| < |divisor| (unsigned compare of the absolute values), skip CALC.
  - Set quo=0 and rem=|dividend|, then go to FIX.
  - DONE is reached at cycle 2. The sign rules still apply.
- Undefined: no compare logic is built. All non-zero divisors take the full WIDTH+2 cycle latency.

Test Plan:
1. Unsigned 100 / 7, i_signed=0.
   - DONE pulse at cycle 34.
   - quotient=14, remainder=2, o_busy high on cycles 0..33.
2. Signed -7 / 2, i.e. 0xFFFFFFF9 / 2.
   - quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
   - Signed 7 / -2 gives quotient=-3, remainder=1.
3. Divide by zero, 0x12345678 / 0.
   - o_done at cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678, o_div_by_zero=1.
   - A following 9 / 3 returns quotient=3, remainder=0 and clears o_div_by_zero.
4. Signed 0x80000000 / 0xFFFFFFFF.
   - quotient=0x80000000, remainder=0, o_div_by_zero=0.
5. Cancel and ignored start.
   - Start 50 / 5, then pulse i_cancel at cycle 10.
   - o_busy=0 at cycle 11, no o_done, outputs unchanged from the previous op.
   - i_start pulsed at cycle 5 of a separate op has no effect on that op's result.
6. resetn low at cycle 20 of an op.
   - Next cycle: state IDLE and all outputs 0.
   - With DIV_EARLY_OUT_EN defined: 3 / 10 returns quotient=0, remainder=3, with o_done at cycle 2.

Source files
------------

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - radix-2 restoring divider for DIV/DIVU; optional DIV_EARLY_OUT_EN skips CALC when |dividend| < |divisor|
module iterative_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_commit;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div_abs;
    logic [CNT_W-1:0]   r_count;
    logic               r_signed;
    logic               r_dvd_neg;
    logic               r_dvs_neg;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic               w_dvs_zero;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_dvd_abs  = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    assign w_dvs_abs  = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
    assign w_dvs_zero = (i_divisor == '0);

`ifdef DIV_EARLY_OUT_EN
    logic w_early;
    assign w_early = !w_dvs_zero && (w_dvd_abs < w_dvs_abs);
`endif

    // The trial difference's MSB is its sign: the shifted remainder never exceeds 2*divisor-1.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div_abs};

    assign w_quo_fix = (r_signed && (r_dvd_neg ^ r_dvs_neg)) ? -r_quo : r_quo;
    assign w_rem_fix = (r_signed && r_dvd_neg) ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_cancel) begin
                    o_busy = 1'b1;
                    w_load = 1'b1;
                    if (w_dvs_zero) w_next_state = S_DONE;
`ifdef DIV_EARLY_OUT_EN
                    else if (w_early) w_next_state = S_FIX;
`endif
                    else w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (i_cancel)                      w_next_state = S_IDLE;
                else if (r_count == CNT_W'(1))     w_next_state = S_FIX;
            end
            S_FIX: begin
                o_busy = 1'b1;
                if (i_cancel) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DONE;
                    w_commit     = 1'b1;
                end
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Results land on entry to DONE so they are already valid while o_done is high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem         <= '0;
            r_quo         <= '0;
            r_div_abs     <= '0;
            r_count       <= '0;
            r_signed      <= 1'b0;
            r_dvd_neg     <= 1'b0;
            r_dvs_neg     <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            if (w_load) begin
                r_signed  <= i_signed;
                r_dvd_neg <= i_signed & i_dividend[WIDTH-1];
                r_dvs_neg <= i_signed & i_divisor[WIDTH-1];
                r_div_abs <= w_dvs_abs;
                r_count   <= CNT_W'(WIDTH);
                r_rem     <= '0;
                r_quo     <= w_dvd_abs;
`ifdef DIV_EARLY_OUT_EN
                if (w_early) begin
                    r_rem <= w_dvd_abs;
                    r_quo <= '0;
                end
`endif
                if (w_dvs_zero) begin
                    r_quotient    <= '1;
                    r_remainder   <= i_dividend;
                    r_div_by_zero <= 1'b1;
                end
            end else if (r_state == S_CALC) begin
                r_count <= r_count - CNT_W'(1);
                if (!w_trial[WIDTH]) begin
                    r_rem <= w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
            end
            if (w_commit) begin
                r_quotient    <= w_quo_fix;
                r_remainder   <= w_rem_fix;
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign o_done        = (r_state == S_DONE);
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking random bench for iterative_divider against an arithmetic model
module tb_iterative_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         i_start = 1'b0;
    logic         i_signed = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         i_cancel = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;

    iterative_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .i_start(i_start), .i_signed(i_signed),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .i_cancel(i_cancel),
        .o_busy(o_busy), .o_done(o_done), .o_quotient(o_quotient),
        .o_remainder(o_remainder), .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain division with truncation toward zero, plus the special cases.
    task automatic model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
            return;
        end
        dz = 1'b0;
        if (!sg) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
        lat = W + 2;
`ifdef DIV_EARLY_OUT_EN
        if (sa < sb) lat = 2;
`endif
    endtask

    task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b, input int junk_at);
        int lat;
        int cyc;
        int busy_low;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic dz;
        model(sg, a, b, q, r, dz, lat);
        @(posedge clk); #1;
        i_start = 1'b1; i_signed = sg; i_dividend = a; i_divisor = b;
        @(negedge clk);
        check("busy_start", o_busy, 1);
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1;
        busy_low = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (o_done) break;
            if (!o_busy) busy_low++;
            @(posedge clk); #1;
            cyc++;
            if (cyc == junk_at) begin
                i_start = 1'b1; i_dividend = ~a; i_divisor = b + 1; i_signed = ~sg;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check("done_latency", cyc, lat);
        check("busy_during_op", busy_low, 0);
        check("busy_at_done", o_busy, 0);
        check("quotient", o_quotient, q);
        check("remainder", o_remainder, r);
        check("div_by_zero", o_div_by_zero, dz);
        exp_q = q; exp_r = r; exp_dz = dz;
    endtask

    initial begin
        int dones;
        int bad_out;
        logic [W-1:0] a;
        logic [W-1:0] b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_quo", o_quotient, 0);
        check("rst_rem", o_remainder, 0);
        check("rst_dz", o_div_by_zero, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(1'b0, 32'h1234_5678, 32'd0, 0);
        run_op(1'b0, 32'd9, 32'd3, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'd1000, 32'd13, 5);

        // Cancel mid-CALC: no done and results must stay from the previous operation.
        @(posedge clk); #1;
        i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd50; i_divisor = 32'd5;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        i_cancel = 1'b1;
        @(posedge clk); #1;
        i_cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", o_busy, 0);
        dones = 0;
        bad_out = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (o_quotient !== exp_q || o_remainder !== exp_r || o_div_by_zero !== exp_dz) bad_out++;
        end
        check("cancel_no_done", dones, 0);
        check("cancel_outputs_held", bad_out, 0);

        @(posedge clk); #1;
        i_start = 1'b1; i_cancel = 1'b1; i_dividend = 32'd8; i_divisor = 32'd2;
        @(negedge clk);
        check("cancel_start_busy", o_busy, 0);
        @(posedge clk); #1;
        i_start = 1'b0; i_cancel = 1'b0;
        @(negedge clk);
        check("cancel_start_idle", o_busy, 0);

        // Reset in the middle of an operation clears everything.
        run_op(1'b0, 32'd100, 32'd7, 0);
        @(posedge clk); #1;
        i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd77; i_divisor = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        check("midrst_quo", o_quotient, 0);
        check("midrst_rem", o_remainder, 0);
        check("midrst_dz", o_div_by_zero, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op(1'b0, 32'd3, 32'd10, 0);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd10, 0);

        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
                3: b = 0;
                default: begin
                    b = $urandom;
                    a = $urandom_range(0, 1000);
                end
            endcase
            run_op($urandom_range(0, 1), a, b, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
